// File: rtl/dbg_pkg.sv
// dbg_pkg: shared FSM states, default SOF byte and snapshot source tags for dbg_frame_tx
package dbg_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SOF, ST_ID, ST_LEN, ST_PAYLOAD, ST_CSUM, ST_DONE} state_t;
  localparam logic [7:0] FRAME_SOF_DEF = 8'hA5;
  localparam logic [7:0] IF_ID = 8'h01;
  localparam logic [7:0] ID_EX = 8'h02;
  localparam logic [7:0] EX_MEM = 8'h03;
  localparam logic [7:0] MEM_WB = 8'h04;
  localparam logic [7:0] REGS = 8'h05;
  localparam logic [7:0] DMEM = 8'h06;
endpackage

// File: rtl/dbg_frame_tx_if.sv
// dbg_frame_tx_if: debugger command/snapshot inputs and UART TX FIFO handshake of dbg_frame_tx
interface dbg_frame_tx_if #(parameter int DATA_WIDTH = 129);
  logic i_start;
  logic [7:0] i_frame_id;
  logic [DATA_WIDTH-1:0] i_snapshot;
  logic i_tx_full;
  logic [7:0] o_tx_data;
  logic o_tx_wr;
  logic o_busy;
  logic o_done;
  modport master (output i_start, i_frame_id, i_snapshot, i_tx_full, input o_tx_data, o_tx_wr, o_busy, o_done);
  modport slave (input i_start, i_frame_id, i_snapshot, i_tx_full, output o_tx_data, o_tx_wr, o_busy, o_done);
endinterface

// File: rtl/dbg_frame_csum.sv
// dbg_frame_csum: next running frame checksum; XOR by default, CRC-8 (poly 0x07, MSB-first) when DBG_FRAME_CRC8_EN is defined
module dbg_frame_csum (
  input  logic [7:0] csum_i,
  input  logic [7:0] byte_i,
  output logic [7:0] csum_o
);
`ifdef DBG_FRAME_CRC8_EN
  // fold the byte into the CRC one bit per polynomial step, MSB first
  always_comb begin
    csum_o = csum_i ^ byte_i;
    for (int b = 0; b < 8; b++) csum_o = csum_o[7] ? {csum_o[6:0], 1'b0} ^ 8'h07 : {csum_o[6:0], 1'b0};
  end
`else
  assign csum_o = csum_i ^ byte_i;
`endif
endmodule

// File: rtl/dbg_frame_tx.sv
// dbg_frame_tx: serialises a captured snapshot as SOF, ID, LEN, payload (LSB byte first), checksum; CRC-8 checksum with DBG_FRAME_CRC8_EN
module dbg_frame_tx import dbg_pkg::*; #(
  parameter int DATA_WIDTH = 129,
  parameter logic [7:0] FRAME_SOF = FRAME_SOF_DEF
) (
  input logic i_clk,
  input logic i_rst,
  dbg_frame_tx_if.slave bus
);
  localparam int PAYLOAD_BYTES = (DATA_WIDTH + 7) / 8;
  localparam int SW = PAYLOAD_BYTES * 8;
  localparam logic [7:0] LEN = 8'(PAYLOAD_BYTES);
  state_t state_q, state_d;
  logic [SW-1:0] sh_q, sh_d;
  logic [7:0] idx_q, idx_d, id_q, id_d, csum_q, csum_d, data_q, data_d;
  logic [7:0] byte_cur, csum_nx;
  logic wr_q, wr_d, busy_q, busy_d, done_q, done_d, emit;
  assign emit = !bus.i_tx_full && state_q inside {ST_SOF, ST_ID, ST_LEN, ST_PAYLOAD, ST_CSUM};
  assign byte_cur = state_q == ST_SOF ? FRAME_SOF :
                    state_q == ST_ID ? id_q :
                    state_q == ST_LEN ? LEN :
                    state_q == ST_PAYLOAD ? sh_q[7:0] : csum_q;
  dbg_frame_csum u_csum (.csum_i(csum_q), .byte_i(byte_cur), .csum_o(csum_nx));
  // next state: capture on start, one byte per non-full cycle, checksum folds ID/LEN/payload only
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    idx_d = idx_q;
    id_d = id_q;
    csum_d = csum_q;
    data_d = emit ? byte_cur : data_q;
    wr_d = emit;
    busy_d = busy_q;
    done_d = 1'b0;
    if (emit && state_q inside {ST_ID, ST_LEN, ST_PAYLOAD}) csum_d = csum_nx;
    case (state_q)
      ST_IDLE: if (bus.i_start) begin
        state_d = ST_SOF;
        sh_d = SW'(bus.i_snapshot);
        id_d = bus.i_frame_id;
        csum_d = '0;
        idx_d = '0;
        busy_d = 1'b1;
      end
      ST_SOF: if (emit) state_d = ST_ID;
      ST_ID: if (emit) state_d = ST_LEN;
      ST_LEN: if (emit) state_d = ST_PAYLOAD;
      ST_PAYLOAD: if (emit) begin
        sh_d = sh_q >> 8;
        idx_d = idx_q == LEN - 8'd1 ? 8'd0 : idx_q + 8'd1;
        state_d = idx_q == LEN - 8'd1 ? ST_CSUM : ST_PAYLOAD;
      end
      ST_CSUM: if (emit) state_d = ST_DONE;
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // state and registered outputs; i_rst low clears everything on the next edge
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      sh_q <= '0;
      idx_q <= '0;
      id_q <= '0;
      csum_q <= '0;
      data_q <= '0;
      wr_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      idx_q <= idx_d;
      id_q <= id_d;
      csum_q <= csum_d;
      data_q <= data_d;
      wr_q <= wr_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign bus.o_tx_data = data_q;
  assign bus.o_tx_wr = wr_q;
  assign bus.o_busy = busy_q;
  assign bus.o_done = done_q;
endmodule

// File: tb/tb_dbg_frame_tx.sv
// tb_dbg_frame_tx: randomized frames against a queue-based frame model with a decoupled byte/done monitor
module tb_dbg_frame_tx;
  import dbg_pkg::*;
  localparam int DW = 129;
  localparam int PB = (DW + 7) / 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  dbg_frame_tx_if #(.DATA_WIDTH(DW)) bus ();
  dbg_frame_tx #(.DATA_WIDTH(DW)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  logic [7:0] exp_q[$];
  int n_vec = 0, n_err = 0, cyc = 0, done_cnt = 0, wr_tot = 0, pos = 0;
  int start_cyc = 0, extra = 0, to_cnt = 0, to_seen = 0, exp_done = 0;
  logic timed = 1'b0, full_s = 1'b0, rst_s = 1'b0, prev_wr = 1'b0;
  function automatic logic [7:0] ref_csum(input logic [7:0] c, input logic [7:0] b);
`ifdef DBG_FRAME_CRC8_EN
    logic [15:0] r = {c ^ b, 8'h00};
    for (int i = 15; i >= 8; i--) if (r[i]) r = r ^ (16'h107 << (i - 8));
    return r[7:0];
`else
    return c ^ b;
`endif
  endfunction
  task automatic push_frame(input logic [7:0] id, input logic [DW-1:0] s);
    logic [7:0] ck = 8'h00;
    logic [7:0] b;
    exp_q.push_back(8'hA5);
    exp_q.push_back(id);
    ck = ref_csum(ck, id);
    exp_q.push_back(8'(PB));
    ck = ref_csum(ck, 8'(PB));
    for (int i = 0; i < PB; i++) begin
      b = 8'(s >> (8 * i));
      exp_q.push_back(b);
      ck = ref_csum(ck, b);
    end
    exp_q.push_back(ck);
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, req, cyc);
    end
  endtask
  always @(posedge clk) begin
    cyc <= cyc + 1;
    full_s <= bus.i_tx_full;
    rst_s <= rst;
  end
  initial forever begin
    @(negedge clk);
    if (!rst_s) begin
      chk("reset_tx_wr", 32'(bus.o_tx_wr), 0);
      chk("reset_busy", 32'(bus.o_busy), 0);
      chk("reset_done", 32'(bus.o_done), 0);
      chk("reset_tx_data", 32'(bus.o_tx_data), 0);
      exp_q.delete();
      pos = 0;
    end else begin
      if (bus.o_tx_wr) begin
        chk("wr_while_full", 32'(full_s), 0);
        chk("busy_during_wr", 32'(bus.o_busy), 1);
        if (pos == 0 && timed) chk("first_wr_latency", cyc - start_cyc, 2);
        chk("byte_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk($sformatf("byte%0d", pos), 32'(bus.o_tx_data), 32'(exp_q.pop_front()));
        pos++;
        wr_tot++;
      end
      if (bus.o_done) begin
        chk("done_after_last_wr", 32'(prev_wr), 1);
        chk("bytes_left_at_done", exp_q.size(), 0);
        chk("busy_at_done", 32'(bus.o_busy), 0);
        chk("frame_len", pos, PB + 4);
        if (timed) chk("done_latency", cyc - start_cyc, PB + 6 + extra);
        pos = 0;
        done_cnt++;
      end
    end
    if (to_cnt != to_seen) begin
      chk("done_timeout", done_cnt, exp_done);
      to_seen = to_cnt;
    end
    prev_wr = bus.o_tx_wr;
  end
  task automatic send(input logic [7:0] id, input logic [DW-1:0] s, input int mode, input bit dup);
    int k = 0;
    int d0 = done_cnt;
    push_frame(id, s);
    start_cyc = cyc;
    timed = mode != 1;
    extra = mode == 2 ? 5 : 0;
    bus.i_start = 1'b1;
    bus.i_frame_id = id;
    bus.i_snapshot = s;
    bus.i_tx_full = mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    while (done_cnt == d0 && k < 400) begin
      @(negedge clk);
      k++;
      bus.i_start = dup && k == 2;
      if (dup && k == 2) begin
        bus.i_snapshot = ~s;
        bus.i_frame_id = ~id;
      end
      bus.i_tx_full = mode == 1 ? 1'($urandom_range(0, 1)) : (mode == 2 && k >= 3 && k <= 7);
    end
    bus.i_start = 1'b0;
    bus.i_tx_full = 1'b0;
    if (done_cnt == d0) begin
      exp_done = d0 + 1;
      to_cnt++;
    end
    @(negedge clk);
  endtask
  task automatic reset_mid(input logic [7:0] id, input logic [DW-1:0] s);
    int k = 0;
    int w0 = wr_tot;
    push_frame(id, s);
    timed = 1'b0;
    bus.i_start = 1'b1;
    bus.i_frame_id = id;
    bus.i_snapshot = s;
    while (wr_tot < w0 + 3 && k < 100) begin
      @(negedge clk);
      k++;
      bus.i_start = 1'b0;
    end
    if (wr_tot < w0 + 3) begin
      exp_done = done_cnt + 1;
      to_cnt++;
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  initial begin
    logic [DW-1:0] s;
    bus.i_start = 1'b0;
    bus.i_frame_id = 8'h00;
    bus.i_snapshot = '0;
    bus.i_tx_full = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    s = '0;
    s[DW-1] = 1'b1;
    s[15:0] = 16'hBEEF;
    send(ID_EX, s, 0, 1'b0);
    send(EX_MEM, DW'(16'h0201), 0, 1'b0);
    send(EX_MEM, DW'(16'h0201), 2, 1'b0);
    send(IF_ID, DW'(64'h0123_4567_89AB_CDEF), 0, 1'b1);
    reset_mid(MEM_WB, DW'({$urandom, $urandom, $urandom, $urandom, $urandom}));
    send(REGS, DW'({$urandom, $urandom, $urandom, $urandom, $urandom}), 0, 1'b0);
    send(DMEM, '0, 1, 1'b0);
    for (int i = 0; i < 30; i++)
      send(8'($urandom), DW'({$urandom, $urandom, $urandom, $urandom, $urandom}), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
